dzcpu_useq: RTL and testbench

Micro-sequencer for the dzcpu core. Reads the microcode ROM: it latches each fetched opcode byte, indexes the main or CB dispatch LUT, and walks the micro-PC through the ROM flow until an end-of-flow micro-op. It decodes each micro-op's flow-control field into a PC-increment strobe, a flag-update strobe and an instruction-done strobe for the datapath. It sits between the memory read-data bus, the two dispatch LUTs and the ROM.

---
 rtl/dzcpu_useq_if.sv | 31 +++
 rtl/dzcpu_useq.sv | 135 +++++++++++++
 tb/tb_dzcpu_useq.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dzcpu_useq_if.sv
// Bus bundle between the dzcpu micro-sequencer and its surroundings:
// memory read data, the two dispatch LUTs, the microcode ROM and the datapath strobes.
interface dzcpu_useq_if;
    logic [7:0] iMemByte;
    logic       iStall;
    logic [7:0] iLutIdx;
    logic [7:0] iCbLutIdx;
    logic [3:0] iFlow;
    logic       iJcb;
    logic       iFlagZ;
    logic [7:0] oMop;
    logic [7:0] oUopAddr;
    logic       oUopValid;
    logic       oPcInc;
    logic       oFlagUpdate;
    logic       oInstrDone;
    logic       oCbMode;
    logic       oUpcOverflow;

    modport slave (
        input  iMemByte, iStall, iLutIdx, iCbLutIdx, iFlow, iJcb, iFlagZ,
        output oMop, oUopAddr, oUopValid, oPcInc, oFlagUpdate, oInstrDone,
        output oCbMode, oUpcOverflow
    );

    modport master (
        output iMemByte, iStall, iLutIdx, iCbLutIdx, iFlow, iJcb, iFlagZ,
        input  oMop, oUopAddr, oUopValid, oPcInc, oFlagUpdate, oInstrDone,
        input  oCbMode, oUpcOverflow
    );
endinterface

// File: rtl/dzcpu_useq.sv
// dzcpu micro-sequencer: latches the opcode, dispatches through the main/CB LUT and
// walks the micro-PC through the ROM, turning each flow field into datapath strobes.
module dzcpu_useq (
    input  logic         iClock,
    input  logic         iReset,
    dzcpu_useq_if.slave  bus
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [7:0] mop, mop_next;
    logic [7:0] upc, upc_next;
    logic       cb, cb_next;
    logic       ovf, ovf_next;

    logic       flow_inc;
    logic       flow_fu;
    logic       flow_eof;

    logic       uop_valid;
    logic       pc_inc;
    logic       flag_update;
    logic       instr_done;

    // Flow field decode; reserved codes and nop fall through as a plain op.
    always_comb begin
        flow_inc = 1'b0;
        flow_fu  = 1'b0;
        flow_eof = 1'b0;
        case (bus.iFlow)
            4'd1: flow_inc = 1'b1;
            4'd2: flow_eof = 1'b1;
            4'd3: begin
                flow_inc = 1'b1;
                flow_eof = 1'b1;
            end
            4'd4: begin
                flow_fu  = 1'b1;
                flow_eof = 1'b1;
            end
            4'd5: begin
                flow_inc = 1'b1;
                flow_fu  = 1'b1;
                flow_eof = 1'b1;
            end
            4'd6: begin
                flow_inc = 1'b1;
                flow_eof = bus.iFlagZ;
            end
            4'd7: begin
                flow_inc = 1'b1;
                flow_eof = ~bus.iFlagZ;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next  = state;
        mop_next    = mop;
        upc_next    = upc;
        cb_next     = cb;
        ovf_next    = ovf;
        uop_valid   = 1'b0;
        pc_inc      = 1'b0;
        flag_update = 1'b0;
        instr_done  = 1'b0;
        case (state)
            FETCH: begin
                if (!bus.iStall) begin
                    mop_next   = bus.iMemByte;
                    state_next = DECODE;
                end
            end
            // The LUTs read the registered opcode, so a stall here cannot corrupt dispatch.
            DECODE: begin
                upc_next   = cb ? bus.iCbLutIdx : bus.iLutIdx;
                cb_next    = 1'b0;
                state_next = EXEC;
            end
            EXEC: begin
                if (!bus.iStall) begin
                    uop_valid = 1'b1;
                    pc_inc    = flow_inc;
                    if (bus.iJcb) begin
                        // A CB prefix ends this pass without completing the instruction.
                        cb_next    = 1'b1;
                        state_next = FETCH;
                    end else if (flow_eof) begin
                        flag_update = flow_fu;
                        instr_done  = 1'b1;
                        state_next  = FETCH;
                    end else begin
                        upc_next = upc + 8'd1;
                        if (upc == 8'hFF) begin
                            ovf_next = 1'b1;
                        end
                    end
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state <= FETCH;
            mop   <= 8'h00;
            upc   <= 8'h00;
            cb    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            mop   <= mop_next;
            upc   <= upc_next;
            cb    <= cb_next;
            ovf   <= ovf_next;
        end
    end

    assign bus.oMop         = mop;
    assign bus.oUopAddr     = upc;
    assign bus.oCbMode      = cb;
    assign bus.oUpcOverflow = ovf;
    assign bus.oUopValid    = uop_valid;
    assign bus.oPcInc       = pc_inc;
    assign bus.oFlagUpdate  = flag_update;
    assign bus.oInstrDone   = instr_done;

endmodule

// File: tb/tb_dzcpu_useq.sv
// Scoreboard bench for dzcpu_useq: an instruction-level model predicts every executed
// uop, a negedge monitor pops and compares each one the sequencer presents.
module tb_dzcpu_useq;

    logic iClock;
    logic iReset;

    dzcpu_useq_if bus ();

    dzcpu_useq dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (bus)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] mop;
        logic       pc_inc;
        logic       fu;
        logic       done;
        logic       ovf;
        logic       cb;
    } exp_t;

    logic [3:0] flow_rom [256];
    logic       jcb_rom  [256];
    logic [7:0] main_lut [256];
    logic [7:0] cb_lut   [256];

    exp_t expq [$];
    int   checks;
    int   errors;
    int   pc_seen;
    logic mon_en;
    logic cb_m;
    logic ovf_m;

    // ROM and LUTs are combinational on the sequencer's registered outputs.
    assign bus.iFlow     = flow_rom[bus.oUopAddr];
    assign bus.iJcb      = jcb_rom[bus.oUopAddr];
    assign bus.iLutIdx   = main_lut[bus.oMop];
    assign bus.iCbLutIdx = cb_lut[bus.oMop];

    initial begin
        iClock = 1'b0;
        forever #5 iClock = ~iClock;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Walk one fetch's worth of uops from the dispatch entry and queue the expected trace.
    function automatic int buildTrace(input logic [7:0] op, input logic z);
        logic [7:0] a;
        logic [3:0] f;
        logic       j;
        logic       ends;
        exp_t       e;
        int         n;
        n = 0;
        a = cb_m ? cb_lut[op] : main_lut[op];
        cb_m = 1'b0;
        for (int s = 0; s < 300; s++) begin
            f    = flow_rom[a];
            j    = jcb_rom[a];
            ends = (f inside {4'd2, 4'd3, 4'd4, 4'd5}) || (f == 4'd6 && z) || (f == 4'd7 && !z);
            e.addr   = a;
            e.mop    = op;
            e.pc_inc = f inside {4'd1, 4'd3, 4'd5, 4'd6, 4'd7};
            e.fu     = !j && (f inside {4'd4, 4'd5});
            e.done   = !j && ends;
            e.ovf    = ovf_m;
            e.cb     = 1'b0;
            expq.push_back(e);
            n++;
            if (j) begin
                cb_m = 1'b1;
                break;
            end
            if (ends) break;
            if (a == 8'hFF) ovf_m = 1'b1;
            a = a + 8'd1;
        end
        return n;
    endfunction

    // Runs one fetch from FETCH back to FETCH; fixed_stalls<0 means random stalls everywhere.
    task automatic applyStimulus(input logic [7:0] op, input logic z, input int fixed_stalls);
        int n;
        int st;
        n = buildTrace(op, z);
        bus.iMemByte = op;
        bus.iFlagZ   = z;
        st = (fixed_stalls < 0) ? $urandom_range(0, 2) : 0;
        repeat (st) begin
            bus.iStall = 1'b1;
            @(posedge iClock); #1;
        end
        bus.iStall = 1'b0;
        @(posedge iClock); #1;
        bus.iStall = (fixed_stalls < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge iClock); #1;
        for (int i = 0; i < n; i++) begin
            if (fixed_stalls < 0)
                st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            else
                st = (i == 0) ? fixed_stalls : 0;
            repeat (st) begin
                bus.iStall = 1'b1;
                @(posedge iClock); #1;
            end
            bus.iStall = 1'b0;
            @(posedge iClock); #1;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge iClock);
            if (bus.oPcInc) pc_seen++;
            if (mon_en) begin
                if (bus.oUopValid) begin
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_uop: addr=%0d with no expected uop queued", bus.oUopAddr);
                    end else begin
                        e = expq.pop_front();
                        if (bus.oUopAddr !== e.addr || bus.oMop !== e.mop || bus.oPcInc !== e.pc_inc ||
                            bus.oFlagUpdate !== e.fu || bus.oInstrDone !== e.done ||
                            bus.oUpcOverflow !== e.ovf || bus.oCbMode !== e.cb) begin
                            errors++;
                            $display("[TB] FAIL uop: got addr=%0d mop=%h pc=%b fu=%b done=%b ovf=%b cb=%b, expected addr=%0d mop=%h pc=%b fu=%b done=%b ovf=%b cb=%b",
                                     bus.oUopAddr, bus.oMop, bus.oPcInc, bus.oFlagUpdate, bus.oInstrDone,
                                     bus.oUpcOverflow, bus.oCbMode, e.addr, e.mop, e.pc_inc, e.fu, e.done,
                                     e.ovf, e.cb);
                        end
                    end
                end else begin
                    checkOutput("idle_strobes", int'({bus.oPcInc, bus.oFlagUpdate, bus.oInstrDone}), 0);
                end
            end
        end
    end

    initial begin
        int pc0;
        checks  = 0;
        errors  = 0;
        pc_seen = 0;
        mon_en  = 1'b0;
        cb_m    = 1'b0;
        ovf_m   = 1'b0;
        for (int i = 0; i < 256; i++) begin
            flow_rom[i] = 4'd2;
            jcb_rom[i]  = 1'b0;
            main_lut[i] = 8'd0;
            cb_lut[i]   = 8'd0;
        end
        main_lut[8'h0C] = 8'd32; flow_rom[32] = 4'd3;
        main_lut[8'h21] = 8'd17;
        flow_rom[17] = 4'd1; flow_rom[18] = 4'd0; flow_rom[19] = 4'd6;
        flow_rom[20] = 4'd0; flow_rom[21] = 4'd0; flow_rom[22] = 4'd2;
        main_lut[8'hCB] = 8'd13;
        flow_rom[13] = 4'd0; flow_rom[14] = 4'd0; flow_rom[15] = 4'd1; jcb_rom[15] = 1'b1;
        cb_lut[8'h7C] = 8'd16; flow_rom[16] = 4'd4;
        main_lut[8'h40] = 8'd40; flow_rom[40] = 4'd1; flow_rom[41] = 4'd2;
        main_lut[8'hFF] = 8'd255; flow_rom[255] = 4'd0;
        main_lut[8'hA5] = 8'd50;
        flow_rom[50] = 4'd1; flow_rom[51] = 4'd1; flow_rom[52] = 4'd1; flow_rom[53] = 4'd2;

        bus.iMemByte = 8'h00;
        bus.iStall   = 1'b0;
        bus.iFlagZ   = 1'b0;
        iReset       = 1'b1;
        repeat (2) @(posedge iClock);
        #1;
        checkOutput("reset_uop_valid", int'(bus.oUopValid), 0);
        checkOutput("reset_strobes", int'({bus.oPcInc, bus.oFlagUpdate, bus.oInstrDone}), 0);
        iReset = 1'b0;

        // Abort an instruction in its first EXEC cycle.
        bus.iMemByte = 8'hA5;
        @(posedge iClock); #1;
        @(posedge iClock); #1;
        checkOutput("exec_addr", int'(bus.oUopAddr), 50);
        checkOutput("exec_pc_inc", int'(bus.oPcInc), 1);
        #1 iReset = 1'b1;
        #1;
        checkOutput("abort_strobes", int'({bus.oUopValid, bus.oPcInc, bus.oFlagUpdate, bus.oInstrDone}), 0);
        @(posedge iClock); #1;
        iReset = 1'b0;
        checkOutput("abort_addr", int'(bus.oUopAddr), 0);
        checkOutput("abort_mop", int'(bus.oMop), 0);
        checkOutput("abort_cb", int'(bus.oCbMode), 0);
        checkOutput("abort_ovf", int'(bus.oUpcOverflow), 0);

        mon_en = 1'b1;
        applyStimulus(8'h0C, 1'b0, 0);
        applyStimulus(8'h21, 1'b1, 0);
        pc0 = pc_seen;
        applyStimulus(8'h21, 1'b0, 0);
        checkOutput("z0_pc_inc_count", pc_seen - pc0, 2);
        applyStimulus(8'hCB, 1'b0, 0);
        checkOutput("cb_mode_after_prefix", int'(bus.oCbMode), int'(cb_m));
        applyStimulus(8'h7C, 1'b0, 0);
        checkOutput("cb_mode_after_cb", int'(bus.oCbMode), int'(cb_m));
        pc0 = pc_seen;
        applyStimulus(8'h40, 1'b0, 3);
        checkOutput("stall_pc_inc_count", pc_seen - pc0, 1);
        applyStimulus(8'hFF, 1'b0, 0);
        checkOutput("wrap_addr", int'(bus.oUopAddr), 0);
        checkOutput("wrap_ovf", int'(bus.oUpcOverflow), int'(ovf_m));

        // Random ROM; every 16th word is an unconditional end so flows stay short.
        for (int i = 0; i < 256; i++) begin
            flow_rom[i] = (i % 16 == 15) ? 4'($urandom_range(2, 5)) : 4'($urandom_range(0, 15));
            jcb_rom[i]  = ($urandom_range(0, 9) == 0);
            main_lut[i] = 8'($urandom_range(0, 255));
            cb_lut[i]   = 8'($urandom_range(0, 255));
        end
        for (int k = 0; k < 150; k++) begin
            applyStimulus(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), -1);
        end

        repeat (2) @(posedge iClock);
        #1;
        checkOutput("queue_empty", expq.size(), 0);
        checkOutput("ovf_sticky", int'(bus.oUpcOverflow), int'(ovf_m));
        mon_en = 1'b0;
        iReset = 1'b1;
        #2;
        checkOutput("final_reset_ovf", int'(bus.oUpcOverflow), 0);
        checkOutput("final_reset_cb", int'(bus.oCbMode), 0);
        checkOutput("final_reset_mop", int'(bus.oMop), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
